// File: rtl/control_sequencer.sv
// Hardwired timing-step control unit for the 32-bit bus datapath.
// It decodes the IR and waits on a memory handshake to produce one-hot datapath strobes.
module control_sequencer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        IncPC,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        AND,
    output logic        OR,
    output logic        NEG,
    output logic        NOT,
    output logic        MUL,
    output logic        DIV,
    output logic        ROL,
    output logic        ROR,
    output logic        run,
    output logic        fault,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_T0        = 4'd0,
        S_T1        = 4'd1,
        S_T2        = 4'd2,
        S_T3        = 4'd3,
        S_T4        = 4'd4,
        S_T5        = 4'd5,
        S_T6        = 4'd6,
        S_HALT_STOP = 4'd7,
        S_HALT_OP   = 4'd8,
        S_FAULT     = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [4:0]  op;
    logic [15:0] ra_oh;
    logic [15:0] rb_oh;
    logic [15:0] rc_oh;
    logic        is_alu3;
    logic        is_muldiv;
    logic        is_unary;
    logic        in_wait;
    logic        timeout;
    logic        alu_en;
    logic        unused_ir;

    assign op        = ir[31:27];
    assign ra_oh     = 16'b1 << ir[26:23];
    assign rb_oh     = 16'b1 << ir[22:19];
    assign rc_oh     = 16'b1 << ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign dbg_state = state;

    assign is_alu3   = (op == OP_AND) || (op == OP_OR) || (op == OP_ROR) || (op == OP_ROL);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);

    // Memory wait states: instruction fetch, LD data read, ST data write.
    assign in_wait = (state == S_T1) ||
                     ((state == S_T4) && (op == OP_LD)) ||
                     ((state == S_T5) && (op == OP_ST));
    assign timeout = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_T0;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= 4'd0;
            else if (in_wait && !mem_ready)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_T0: state_next = stop ? S_HALT_STOP : S_T1;
            S_T1: begin
                if (mem_ready)    state_next = S_T2;
                else if (timeout) state_next = S_FAULT;
            end
            S_T2: state_next = S_T3;
            S_T3: begin
                if ((op == OP_LD) || (op == OP_ST) || is_alu3 || is_muldiv || is_unary)
                    state_next = S_T4;
                else if (op == OP_NOP)
                    state_next = S_T0;
                else if (op == OP_HALT)
                    state_next = S_HALT_OP;
                else
                    state_next = S_FAULT;
            end
            S_T4: begin
                if (op == OP_LD) begin
                    if (mem_ready)    state_next = S_T5;
                    else if (timeout) state_next = S_FAULT;
                end else if ((op == OP_ST) || is_alu3 || is_muldiv)
                    state_next = S_T5;
                else if (is_unary)
                    state_next = S_T0;
                else
                    state_next = S_FAULT;
            end
            S_T5: begin
                if (op == OP_ST) begin
                    if (mem_ready)    state_next = S_T0;
                    else if (timeout) state_next = S_FAULT;
                end else if (is_muldiv)
                    state_next = S_T6;
                else
                    state_next = S_T0;
            end
            S_T6:        state_next = S_T0;
            S_HALT_STOP: state_next = stop ? S_HALT_STOP : S_T0;
            S_HALT_OP:   state_next = S_HALT_OP;
            S_FAULT:     state_next = S_FAULT;
            default:     state_next = S_FAULT;
        endcase
    end

    always_comb begin
        Rin = 16'd0; Rout = 16'd0;
        PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; HIin = 1'b0; LOin = 1'b0;
        Zhighout = 1'b0; Zlowout = 1'b0; IncPC = 1'b0; Cout = 1'b0;
        Read = 1'b0; Write = 1'b0;
        alu_en = 1'b0;
        run   = !((state == S_HALT_STOP) || (state == S_HALT_OP) || (state == S_FAULT));
        fault = (state == S_FAULT);
        // Strobes stay quiet for as long as clr is held, not just after the edge.
        if (!clr) begin
            case (state)
                S_T0: if (!stop) begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
                S_T1: begin
                    Read  = 1'b1;
                    MDRin = mem_ready;
                    // A cleared counter marks the first T1 cycle.
                    if (wait_cnt == 4'd0) begin
                        Zlowout = 1'b1; PCin = 1'b1;
                    end
                end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                S_T3: begin
                    if ((op == OP_LD) || (op == OP_ST)) begin
                        Cout = 1'b1; MARin = 1'b1;
                    end else if (is_alu3) begin
                        Rout = rb_oh; Yin = 1'b1;
                    end else if (is_muldiv) begin
                        Rout = ra_oh; Yin = 1'b1;
                    end else if (is_unary) begin
                        Rout = rb_oh; alu_en = 1'b1; Zin = 1'b1;
                    end
                end
                S_T4: begin
                    if (op == OP_LD) begin
                        Read = 1'b1; MDRin = mem_ready;
                    end else if (op == OP_ST) begin
                        Rout = ra_oh; MDRin = 1'b1;
                    end else if (is_alu3) begin
                        Rout = rc_oh; alu_en = 1'b1; Zin = 1'b1;
                    end else if (is_muldiv) begin
                        Rout = rb_oh; alu_en = 1'b1; Zin = 1'b1;
                    end else if (is_unary) begin
                        Zlowout = 1'b1; Rin = ra_oh;
                    end
                end
                S_T5: begin
                    if (op == OP_LD) begin
                        MDRout = 1'b1; Rin = ra_oh;
                    end else if (op == OP_ST) begin
                        Write = 1'b1;
                    end else if (is_alu3) begin
                        Zlowout = 1'b1; Rin = ra_oh;
                    end else if (is_muldiv) begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                end
                S_T6: if (is_muldiv) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end
                default: ;
            endcase
        end
        AND = alu_en && (op == OP_AND);
        OR  = alu_en && (op == OP_OR);
        NEG = alu_en && (op == OP_NEG);
        NOT = alu_en && (op == OP_NOT);
        MUL = alu_en && (op == OP_MUL);
        DIV = alu_en && (op == OP_DIV);
        ROL = alu_en && (op == OP_ROL);
        ROR = alu_en && (op == OP_ROR);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: steps each timing state and checks
// state, strobes, ALU op and register enables against hand-computed values.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic [15:0] Rin, Rout;
    logic PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin;
    logic Zhighout, Zlowout, IncPC, Cout, Read, Write;
    logic AND, OR, NEG, NOT, MUL, DIV, ROL, ROR;
    logic        run, fault;
    logic [3:0]  dbg_state;

    int tests  = 0;
    int failed = 0;

    control_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .HIin(HIin), .LOin(LOin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .IncPC(IncPC), .Cout(Cout), .Read(Read), .Write(Write),
        .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT), .MUL(MUL), .DIV(DIV),
        .ROL(ROL), .ROR(ROR), .run(run), .fault(fault), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4;
    localparam logic [3:0] T5 = 4'd5, T6 = 4'd6, HS = 4'd7, HO = 4'd8, FL = 4'd9;

    localparam logic [15:0] S_PCIN = 16'h8000, S_PCOUT = 16'h4000, S_IRIN = 16'h2000;
    localparam logic [15:0] S_YIN = 16'h1000, S_ZIN = 16'h0800, S_MARIN = 16'h0400;
    localparam logic [15:0] S_MDRIN = 16'h0200, S_MDROUT = 16'h0100, S_HIIN = 16'h0080;
    localparam logic [15:0] S_LOIN = 16'h0040, S_ZHI = 16'h0020, S_ZLO = 16'h0010;
    localparam logic [15:0] S_INC = 16'h0008, S_COUT = 16'h0004, S_READ = 16'h0002;
    localparam logic [15:0] S_WRITE = 16'h0001;
    localparam logic [15:0] S_FETCH = S_PCOUT | S_MARIN | S_INC | S_ZIN;

    localparam logic [7:0] A_AND = 8'h80, A_OR = 8'h40, A_NEG = 8'h20, A_MUL = 8'h08;

    logic [15:0] strb;
    logic [7:0]  alu;
    assign strb = {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, LOin,
                   Zhighout, Zlowout, IncPC, Cout, Read, Write};
    assign alu  = {AND, OR, NEG, NOT, MUL, DIV, ROL, ROR};

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] st, input logic [15:0] s,
                             input logic [7:0] a, input logic [15:0] rin_e,
                             input logic [15:0] rout_e);
        chk(tag, "state", {28'd0, dbg_state}, {28'd0, st});
        chk(tag, "strobes", {16'd0, strb}, {16'd0, s});
        chk(tag, "alu", {24'd0, alu}, {24'd0, a});
        chk(tag, "Rin", {16'd0, Rin}, {16'd0, rin_e});
        chk(tag, "Rout", {16'd0, Rout}, {16'd0, rout_e});
        chk(tag, "run", {31'd0, run}, {31'd0, (st <= T6)});
        chk(tag, "fault", {31'd0, fault}, {31'd0, (st == FL)});
    endtask

    // One clock step: drive inputs on the falling edge, check after settling.
    task automatic step(input string tag, input logic [31:0] ir_v, input logic rdy,
                        input logic stp, input logic [3:0] st, input logic [15:0] s,
                        input logic [7:0] a, input logic [15:0] rin_e,
                        input logic [15:0] rout_e);
        @(negedge clk);
        clr = 1'b0; ir = ir_v; mem_ready = rdy; stop = stp;
        #1;
        check_all(tag, st, s, a, rin_e, rout_e);
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge clk);
        clr = 1'b1; mem_ready = 1'b0; stop = 1'b0;
        #1;
        check_all(tag, T0, 16'd0, 8'd0, 16'd0, 16'd0);
    endtask

    task automatic fetch_fast(input string tag, input logic [31:0] ir_v);
        step({tag, "_T0"}, ir_v, 1'b0, 1'b0, T0, S_FETCH, 8'd0, 16'd0, 16'd0);
        step({tag, "_T1"}, ir_v, 1'b1, 1'b0, T1, S_ZLO | S_PCIN | S_READ | S_MDRIN,
             8'd0, 16'd0, 16'd0);
        step({tag, "_T2"}, ir_v, 1'b1, 1'b0, T2, S_MDROUT | S_IRIN, 8'd0, 16'd0, 16'd0);
    endtask

    logic [31:0] ir_and, ir_mul, ir_ld, ir_or, ir_st, ir_bad, ir_halt, ir_neg, ir_nop;

    initial begin
        ir_and  = enc(5'b00101, 4'd1, 4'd2, 4'd3);
        ir_mul  = enc(5'b01111, 4'd4, 4'd5, 4'd0);
        ir_ld   = enc(5'b00000, 4'd6, 4'd0, 4'd0);
        ir_or   = enc(5'b00110, 4'd7, 4'd8, 4'd9);
        ir_st   = enc(5'b00001, 4'd10, 4'd0, 4'd0);
        ir_bad  = enc(5'b11111, 4'd0, 4'd0, 4'd0);
        ir_halt = enc(5'b11011, 4'd0, 4'd0, 4'd0);
        ir_neg  = enc(5'b10001, 4'd11, 4'd12, 4'd0);
        ir_nop  = enc(5'b11010, 4'd0, 4'd0, 4'd0);

        clr = 1'b1; ir = 32'd0; mem_ready = 1'b0; stop = 1'b0;
        @(negedge clk); #1;
        check_all("reset", T0, 16'd0, 8'd0, 16'd0, 16'd0);

        // AND R1,R2,R3 with fetch memory ready on the second T1 cycle
        step("and_T0", ir_and, 1'b0, 1'b0, T0, S_FETCH, 8'd0, 16'd0, 16'd0);
        step("and_T1a", ir_and, 1'b0, 1'b0, T1, S_ZLO | S_PCIN | S_READ, 8'd0, 16'd0, 16'd0);
        step("and_T1b", ir_and, 1'b1, 1'b0, T1, S_READ | S_MDRIN, 8'd0, 16'd0, 16'd0);
        step("and_T2", ir_and, 1'b0, 1'b0, T2, S_MDROUT | S_IRIN, 8'd0, 16'd0, 16'd0);
        step("and_T3", ir_and, 1'b0, 1'b0, T3, S_YIN, 8'd0, 16'd0, 16'h0004);
        step("and_T4", ir_and, 1'b0, 1'b0, T4, S_ZIN, A_AND, 16'd0, 16'h0008);
        step("and_T5", ir_and, 1'b0, 1'b0, T5, S_ZLO, 8'd0, 16'h0002, 16'd0);

        // MUL R4,R5; mem_ready in T2 must be ignored
        fetch_fast("mul", ir_mul);
        step("mul_T3", ir_mul, 1'b0, 1'b0, T3, S_YIN, 8'd0, 16'd0, 16'h0010);
        step("mul_T4", ir_mul, 1'b0, 1'b0, T4, S_ZIN, A_MUL, 16'd0, 16'h0020);
        step("mul_T5", ir_mul, 1'b0, 1'b0, T5, S_ZLO | S_LOIN, 8'd0, 16'd0, 16'd0);
        step("mul_T6", ir_mul, 1'b0, 1'b0, T6, S_ZHI | S_HIIN, 8'd0, 16'd0, 16'd0);

        // LD R6 with three cycles of memory wait
        fetch_fast("ld", ir_ld);
        step("ld_T3", ir_ld, 1'b0, 1'b0, T3, S_COUT | S_MARIN, 8'd0, 16'd0, 16'd0);
        for (int i = 0; i < 3; i++)
            step("ld_T4w", ir_ld, 1'b0, 1'b0, T4, S_READ, 8'd0, 16'd0, 16'd0);
        step("ld_T4r", ir_ld, 1'b1, 1'b0, T4, S_READ | S_MDRIN, 8'd0, 16'd0, 16'd0);
        step("ld_T5", ir_ld, 1'b0, 1'b0, T5, S_MDROUT, 8'd0, 16'h0040, 16'd0);

        // OR R7,R8,R9 with stop raised in T4: finishes, then halts at T0
        fetch_fast("or", ir_or);
        step("or_T3", ir_or, 1'b0, 1'b0, T3, S_YIN, 8'd0, 16'd0, 16'h0100);
        step("or_T4", ir_or, 1'b0, 1'b1, T4, S_ZIN, A_OR, 16'd0, 16'h0200);
        step("or_T5", ir_or, 1'b0, 1'b1, T5, S_ZLO, 8'd0, 16'h0080, 16'd0);
        step("stop_T0", ir_or, 1'b0, 1'b1, T0, 16'd0, 8'd0, 16'd0, 16'd0);
        step("stop_halt", ir_or, 1'b0, 1'b0, HS, 16'd0, 8'd0, 16'd0, 16'd0);

        // ST R10 with memory never ready: 15 Write cycles then FAULT
        fetch_fast("st", ir_st);
        step("st_T3", ir_st, 1'b0, 1'b0, T3, S_COUT | S_MARIN, 8'd0, 16'd0, 16'd0);
        step("st_T4", ir_st, 1'b0, 1'b0, T4, S_MDRIN, 8'd0, 16'd0, 16'h0400);
        for (int i = 0; i < 15; i++)
            step("st_T5w", ir_st, 1'b0, 1'b0, T5, S_WRITE, 8'd0, 16'd0, 16'd0);
        step("st_fault", ir_st, 1'b0, 1'b0, FL, 16'd0, 8'd0, 16'd0, 16'd0);
        step("st_fault_rdy", ir_st, 1'b1, 1'b0, FL, 16'd0, 8'd0, 16'd0, 16'd0);
        clr_pulse("st_clr");

        // Illegal opcode faults after T3
        fetch_fast("bad", ir_bad);
        step("bad_T3", ir_bad, 1'b0, 1'b0, T3, 16'd0, 8'd0, 16'd0, 16'd0);
        step("bad_fault", ir_bad, 1'b0, 1'b0, FL, 16'd0, 8'd0, 16'd0, 16'd0);
        clr_pulse("bad_clr");

        // HALT opcode: stop toggling does not release it
        fetch_fast("halt", ir_halt);
        step("halt_T3", ir_halt, 1'b0, 1'b0, T3, 16'd0, 8'd0, 16'd0, 16'd0);
        step("halt_a", ir_halt, 1'b0, 1'b1, HO, 16'd0, 8'd0, 16'd0, 16'd0);
        step("halt_b", ir_halt, 1'b0, 1'b0, HO, 16'd0, 8'd0, 16'd0, 16'd0);
        step("halt_c", ir_halt, 1'b0, 1'b1, HO, 16'd0, 8'd0, 16'd0, 16'd0);
        clr_pulse("halt_clr");

        // NEG R11,R12 then NOP
        fetch_fast("neg", ir_neg);
        step("neg_T3", ir_neg, 1'b0, 1'b0, T3, S_ZIN, A_NEG, 16'd0, 16'h1000);
        step("neg_T4", ir_neg, 1'b0, 1'b0, T4, S_ZLO, 8'd0, 16'h0800, 16'd0);
        fetch_fast("nop", ir_nop);
        step("nop_T3", ir_nop, 1'b0, 1'b0, T3, 16'd0, 8'd0, 16'd0, 16'd0);
        step("nop_T0", ir_nop, 1'b0, 1'b0, T0, S_FETCH, 8'd0, 16'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
